// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared constants for the direct-mapped write-through data cache
package dcache_pkg;

    localparam int DC_ADDR_W  = 32;
    localparam int DC_INDEX_W = 6;
    localparam int DC_OFF_W   = 2;
    localparam int DC_TAG_LSB = DC_INDEX_W + DC_OFF_W;
    localparam int DC_TAG_W   = DC_ADDR_W - DC_TAG_LSB;
    localparam int DC_LINES   = 1 << DC_INDEX_W;

    localparam int S_IDLE   = 0;
    localparam int S_LOOKUP = 1;
    localparam int S_MEM_RD = 2;
    localparam int S_MEM_WR = 3;
    localparam int S_DONE   = 4;
    localparam int STATE_W  = 5;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 5'b00001;
    localparam state_t ST_LOOKUP = 5'b00010;
    localparam state_t ST_MEM_RD = 5'b00100;
    localparam state_t ST_MEM_WR = 5'b01000;
    localparam state_t ST_DONE   = 5'b10000;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - core-side request/ready and backing-memory signals of the data cache
interface dcache_ctrl_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DC_ADDR_W
) ();

    logic              dcache_ren;
    logic              dcache_wen;
    logic [ADDR_W-1:0] dcache_addr;
    logic [31:0]       dcache_wdata;
    logic [3:0]        dcache_wmask;
    logic [31:0]       dcache_rdata;
    logic              dcache_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    // slave is the cache; master is everything around it (core + memory)
    modport slave (
        input  dcache_ren, dcache_wen, dcache_addr, dcache_wdata, dcache_wmask,
        input  mem_rdata, mem_ready,
        output dcache_rdata, dcache_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output dcache_ren, dcache_wen, dcache_addr, dcache_wdata, dcache_wmask,
        output mem_rdata, mem_ready,
        input  dcache_rdata, dcache_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/data storage with combinational read and a single-cycle valid clear
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = DC_INDEX_W,
    parameter int TAG_W   = DC_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic               wr_fill,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_mask
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en && wr_fill) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are never reset; valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx] <= merge_bytes(data_mem[wr_idx], wr_data, wr_mask);
            if (wr_fill) begin
                tag_mem[wr_idx] <= wr_tag;
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W  = DC_ADDR_W,
    parameter int INDEX_W = DC_INDEX_W
) (
    input  logic         clk,
    input  logic         reset,
    dcache_ctrl_if.slave bus,
    output logic [4:0]   state_out
);

    localparam int TAG_LSB = INDEX_W + DC_OFF_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0]  req_addr;
    logic [31:0]        req_wdata;
    logic [3:0]         req_wmask;
    logic               req_we;
    logic [31:0]        rdata_q;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               arr_valid;
    logic [TAG_W-1:0]   arr_tag;
    logic [31:0]        arr_data;
    logic               hit;

    logic               arr_wr_en;
    logic               arr_fill;
    logic [31:0]        arr_wr_data;
    logic [3:0]         arr_wr_mask;
    logic               mem_req_c;
    logic               mem_we_c;
    logic               ready_c;
    logic               unused_addr_lo;

    assign req_idx        = req_addr[TAG_LSB-1:DC_OFF_W];
    assign req_tag        = req_addr[ADDR_W-1:TAG_LSB];
    assign unused_addr_lo = ^req_addr[DC_OFF_W-1:0];
    assign hit            = arr_valid && (arr_tag == req_tag);

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (req_idx),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (arr_wr_en),
        .wr_fill  (arr_fill),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (arr_wr_data),
        .wr_mask  (arr_wr_mask)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = ST_IDLE;
        case (1'b1)
            state[S_IDLE]:   state_nx = (bus.dcache_ren || bus.dcache_wen) ? ST_LOOKUP : ST_IDLE;
            state[S_LOOKUP]: begin
                if (req_we) begin
                    state_nx = ST_MEM_WR;
                end else if (hit) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_MEM_RD;
                end
            end
            state[S_MEM_RD]: state_nx = bus.mem_ready ? ST_DONE : ST_MEM_RD;
            state[S_MEM_WR]: state_nx = bus.mem_ready ? ST_DONE : ST_MEM_WR;
            state[S_DONE]:   state_nx = ST_IDLE;
            default:         state_nx = ST_IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; the core never overlaps them.
    always_ff @(posedge clk) begin
        if (state[S_IDLE] && (bus.dcache_ren || bus.dcache_wen)) begin
            req_addr  <= bus.dcache_addr;
            req_wdata <= bus.dcache_wdata;
            req_wmask <= bus.dcache_wmask;
            req_we    <= bus.dcache_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (state[S_LOOKUP] && !req_we && hit) begin
            rdata_q <= arr_data;
        end else if (state[S_MEM_RD] && bus.mem_ready) begin
            rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        arr_wr_en   = 1'b0;
        arr_fill    = 1'b0;
        arr_wr_data = req_wdata;
        arr_wr_mask = req_wmask;
        mem_req_c   = state[S_MEM_RD] | state[S_MEM_WR];
        mem_we_c    = state[S_MEM_WR];
        ready_c     = state[S_DONE];
        if (state[S_LOOKUP] && req_we && hit) begin
            arr_wr_en = 1'b1;
        end
        if (state[S_MEM_RD] && bus.mem_ready) begin
            arr_wr_en   = 1'b1;
            arr_fill    = 1'b1;
            arr_wr_data = bus.mem_rdata;
            arr_wr_mask = 4'hF;
        end
    end

    assign bus.dcache_ready = ready_c;
    assign bus.dcache_rdata = rdata_q;
    assign bus.mem_req      = mem_req_c;
    assign bus.mem_we       = mem_we_c;
    assign bus.mem_addr     = {req_addr[ADDR_W-1:DC_OFF_W], {DC_OFF_W{1'b0}}};
    assign bus.mem_wdata    = req_wdata;
    assign bus.mem_wmask    = req_wmask;
    assign state_out        = state;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl against a behavioural cache/memory model
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] state_out;

    dcache_ctrl_if #(.ADDR_W(DC_ADDR_W)) bus ();

    dcache_ctrl #(
        .ADDR_W  (DC_ADDR_W),
        .INDEX_W (DC_INDEX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_load;
        bit          fast;
        logic [31:0] rdata;
        int          issue_cyc;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mop_t;

    exp_t exp_q[$];
    mop_t mop_q[$];

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [int unsigned];
    bit          ref_valid [DC_LINES];
    int unsigned ref_tag   [DC_LINES];
    logic [31:0] tb_last_rdata = '0;

    int forced_delay       = -1;
    bit mem_hold           = 1'b0;
    int last_mem_ready_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [31:0] mem_word(input int unsigned w);
        if (!ref_mem.exists(w)) ref_mem[w] = $urandom;
        return ref_mem[w];
    endfunction

    function automatic void clear_ref_cache();
        for (int i = 0; i < DC_LINES; i++) ref_valid[i] = 1'b0;
    endfunction

    // Memory responder: checks each new access against the expected list, answers after 0..3 cycles.
    initial begin : responder
        bit   busy;
        int   delay;
        mop_t m;
        busy = 1'b0;
        delay = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (!reset || mem_hold) begin
                busy = 1'b0;
            end else if (busy && !bus.mem_req) begin
                flag("mem_req_held", "mem_req dropped before mem_ready");
                busy = 1'b0;
            end else if (bus.mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    if (mop_q.size() == 0) begin
                        flag("mem_unexpected", "mem_req with no memory access expected");
                    end else begin
                        m = mop_q.pop_front();
                        check("mem_we", {31'b0, bus.mem_we}, {31'b0, m.we});
                        check("mem_addr", bus.mem_addr, m.addr);
                        if (m.we) begin
                            check("mem_wdata", bus.mem_wdata, m.wdata);
                            check("mem_wmask", {28'b0, bus.mem_wmask}, {28'b0, m.wmask});
                        end
                    end
                    delay = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
                end
                if (delay == 0) begin
                    bus.mem_rdata = bus.mem_we ? $urandom : mem_word(bus.mem_addr >> 2);
                    bus.mem_ready = 1'b1;
                    last_mem_ready_cyc = cyc;
                    busy = 1'b0;
                end else begin
                    delay--;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.dcache_ready) begin
                if (exp_q.size() == 0) begin
                    flag("ready_unexpected", "dcache_ready with no request outstanding");
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_load ? "load_rdata" : "store_rdata_hold", bus.dcache_rdata, e.rdata);
                    if (e.fast) check("hit_latency", cyc - e.issue_cyc, 2);
                    else        check("mem_latency", cyc - last_mem_ready_cyc, 1);
                end
            end
        end
    end

    task automatic issue(input bit is_wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        int unsigned w;
        int          idx;
        int unsigned tg;
        bit          hit;
        logic [31:0] cur;
        exp_t        e;
        mop_t        m;
        w   = addr >> 2;
        idx = int'(w % DC_LINES);
        tg  = w / DC_LINES;
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        @(negedge clk);
        if (is_wr) begin
            m.we = 1'b1; m.addr = {addr[31:2], 2'b00}; m.wdata = wdata; m.wmask = mask;
            mop_q.push_back(m);
            cur = mem_word(w);
            for (int b = 0; b < 4; b++) if (mask[b]) cur[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[w] = cur;
            e.is_load = 1'b0; e.fast = 1'b0; e.rdata = tb_last_rdata;
        end else begin
            e.is_load = 1'b1; e.fast = hit; e.rdata = mem_word(w);
            tb_last_rdata = e.rdata;
            if (!hit) begin
                m.we = 1'b0; m.addr = {addr[31:2], 2'b00}; m.wdata = '0; m.wmask = '0;
                mop_q.push_back(m);
                ref_valid[idx] = 1'b1;
                ref_tag[idx] = tg;
            end
        end
        e.issue_cyc = cyc;
        exp_q.push_back(e);
        bus.dcache_ren   = !is_wr;
        bus.dcache_wen   = is_wr;
        bus.dcache_addr  = addr;
        bus.dcache_wdata = wdata;
        bus.dcache_wmask = mask;
        @(negedge clk);
        bus.dcache_ren   = 1'b0;
        bus.dcache_wen   = 1'b0;
        bus.dcache_addr  = $urandom;
        bus.dcache_wdata = $urandom;
        bus.dcache_wmask = 4'($urandom);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            flag("ready_timeout", "no dcache_ready within 60 cycles");
            exp_q.delete();
            mop_q.delete();
        end
    endtask

    task automatic reset_mid_miss(input logic [31:0] addr);
        mem_hold = 1'b1;
        @(negedge clk);
        bus.dcache_ren  = 1'b1;
        bus.dcache_addr = addr;
        @(negedge clk);
        bus.dcache_ren  = 1'b0;
        for (int k = 0; k < 10 && !bus.mem_req; k++) @(negedge clk);
        check("rst_mid_mem_req_up", {31'b0, bus.mem_req}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_mid_state", {27'b0, state_out}, {27'b0, ST_IDLE});
        check("rst_mid_ready", {31'b0, bus.dcache_ready}, 32'd0);
        check("rst_mid_rdata", bus.dcache_rdata, 32'd0);
        clear_ref_cache();
        tb_last_rdata = '0;
        mem_hold = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin : stimulus
        logic [31:0] a;
        reset            = 1'b0;
        bus.dcache_ren   = 1'b0;
        bus.dcache_wen   = 1'b0;
        bus.dcache_addr  = '0;
        bus.dcache_wdata = '0;
        bus.dcache_wmask = '0;
        clear_ref_cache();
        repeat (3) @(negedge clk);
        check("reset_state", {27'b0, state_out}, {27'b0, ST_IDLE});
        check("reset_ready", {31'b0, bus.dcache_ready}, 32'd0);
        check("reset_rdata", bus.dcache_rdata, 32'd0);
        check("reset_mem_req", {31'b0, bus.mem_req}, 32'd0);
        reset = 1'b1;

        ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        forced_delay = 3;
        issue(1'b0, 32'h100, '0, '0);
        forced_delay = -1;
        issue(1'b0, 32'h100, '0, '0);
        issue(1'b1, 32'h100, 32'h0000_00AA, 4'b0001);
        issue(1'b0, 32'h100, '0, '0);
        issue(1'b1, 32'h200, 32'h1234_5678, 4'hF);
        issue(1'b0, 32'h200, '0, '0);
        forced_delay = 0;
        issue(1'b0, 32'h100, '0, '0);
        forced_delay = -1;

        reset_mid_miss(32'h40);
        issue(1'b0, 32'h100, '0, '0);

        // Few indices and tags so hits, conflicts and write misses all recur.
        repeat (300) begin
            a = ($urandom_range(0, 3) * (4 * DC_LINES)) + ($urandom_range(0, 3) * 4)
                + $urandom_range(0, 3);
            issue(($urandom_range(0, 2) == 0), a, $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
